instruction_fetch: RTL and testbench

//  Reader side of the program memory: holds the PC, drives the PM address, and collects
//  1-3 byte instructions (opcode + operands) from the asynchronous 8-bit PM read port.

---
 rtl/instruction_fetch_pkg.sv | 43 ++++
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch_isa_len_decode.sv | 19 +
 rtl/instruction_fetch.sv | 106 ++++++++++
 tb/tb_instruction_fetch.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - ISA opcodes, length constants, fetch FSM encodings
package instruction_fetch_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_MOVRR = 8'h03;
  localparam logic [7:0] OP_MOVRA = 8'h04;
  localparam logic [7:0] OP_MOVAR = 8'h05;
  localparam logic [7:0] OP_MOVDR = 8'h06;
  localparam logic [7:0] OP_JMP   = 8'h07;
  localparam logic [7:0] OP_JNB   = 8'h09;
  localparam logic [7:0] OP_CLR   = 8'h12;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  localparam logic [1:0] F_OP  = 2'd0;
  localparam logic [1:0] F_OP1 = 2'd1;
  localparam logic [1:0] F_OP2 = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  typedef struct packed {
    logic [1:0] len;
    logic       illegal;
  } len_info_t;

  // Unknown opcodes are treated as single-byte so fetch keeps moving.
  function automatic len_info_t isa_len(input logic [7:0] op);
    len_info_t info;
    info.len     = LEN_1;
    info.illegal = 1'b0;
    case (op)
      OP_NOP, OP_CLR:                     info.len = LEN_1;
      OP_ADD, OP_SUB, OP_MOVRR, OP_JMP:   info.len = LEN_2;
      OP_MOVRA, OP_MOVAR, OP_MOVDR, OP_JNB: info.len = LEN_3;
      default:                            info.illegal = 1'b1;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - PM read port, decoder handshake and redirect bundle
interface instruction_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] opcode;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [1:0]        instr_len;
  logic [ADDR_W-1:0] instr_pc;
  logic              illegal;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_target;

  modport master (
    output pm_addr, instr_valid, opcode, op1, op2, instr_len, instr_pc, illegal,
    input  pm_data, instr_ready, jump_en, jump_target
  );

  modport slave (
    input  pm_addr, instr_valid, opcode, op1, op2, instr_len, instr_pc, illegal,
    output pm_data, instr_ready, jump_en, jump_target
  );
endinterface

// File: rtl/instruction_fetch_isa_len_decode.sv
// rtl/instruction_fetch_isa_len_decode.sv - combinational opcode to length/illegal lookup
module isa_len_decode
  import instruction_fetch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] opcode_i,
  output logic [1:0]        len_o,
  output logic              illegal_o
);
  len_info_t info;
  logic      hi_nz;

  // Bits above the 8-bit ISA field make the opcode illegal on wider ports.
  assign hi_nz     = (opcode_i >> 8) != '0;
  assign info      = isa_len(8'(opcode_i));
  assign len_o     = hi_nz ? LEN_1 : info.len;
  assign illegal_o = hi_nz | info.illegal;
endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, byte-collect FSM and decoder-side instruction register
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master ifb
);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [1:0]        len_q, len_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              illegal_q, illegal_d;
  logic [1:0]        dec_len;
  logic              dec_illegal;
  logic              valid;
  logic [ADDR_W-1:0] pc_inc;

  isa_len_decode #(.DATA_W(DATA_W)) u_len_decode (
    .opcode_i  (ifb.pm_data),
    .len_o     (dec_len),
    .illegal_o (dec_illegal)
  );

  assign valid  = (state_q == HOLD);
  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    len_d     = len_q;
    ipc_d     = ipc_q;
    illegal_d = illegal_q;
    case (state_q)
      F_OP: begin
        opcode_d  = ifb.pm_data;
        op1_d     = '0;
        op2_d     = '0;
        ipc_d     = pc_q;
        len_d     = dec_len;
        illegal_d = dec_illegal;
        pc_d      = pc_inc;
        state_d   = (dec_len == LEN_1) ? HOLD : F_OP1;
      end
      F_OP1: begin
        op1_d   = ifb.pm_data;
        pc_d    = pc_inc;
        state_d = (len_q == LEN_2) ? HOLD : F_OP2;
      end
      F_OP2: begin
        op2_d   = ifb.pm_data;
        pc_d    = pc_inc;
        state_d = HOLD;
      end
      default: begin
        if (ifb.instr_ready) state_d = F_OP;
      end
    endcase
    // Redirect wins for PC/state; any partially collected bytes are never presented.
    if (ifb.jump_en) begin
      pc_d    = ifb.jump_target;
      state_d = F_OP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= F_OP;
      pc_q      <= RESET_PC;
      opcode_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      len_q     <= LEN_1;
      ipc_q     <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      len_q     <= len_d;
      ipc_q     <= ipc_d;
      illegal_q <= illegal_d;
    end
  end

  assign ifb.pm_addr     = pc_q;
  assign ifb.instr_valid = valid;
  assign ifb.opcode      = opcode_q;
  assign ifb.op1         = op1_q;
  assign ifb.op2         = op2_q;
  assign ifb.instr_len   = len_q;
  assign ifb.instr_pc    = ipc_q;
  assign ifb.illegal     = illegal_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed-vector bench for instruction_fetch
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mem  [256];
  logic [7:0] mem2 [256];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  instruction_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

  assign bus.pm_data  = mem[bus.pm_addr];
  assign bus2.pm_data = mem2[bus2.pm_addr];

  instruction_fetch #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .ifb (bus)
  );

  instruction_fetch #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'hFE)) dut2 (
    .clk (clk),
    .rst (rst),
    .ifb (bus2)
  );

  // {valid, opcode, op1, op2, len, instr_pc, illegal, pm_addr}
  wire [43:0] snap  = {bus.instr_valid, bus.opcode, bus.op1, bus.op2, bus.instr_len,
                       bus.instr_pc, bus.illegal, bus.pm_addr};
  wire [43:0] snap2 = {bus2.instr_valid, bus2.opcode, bus2.op1, bus2.op2, bus2.instr_len,
                       bus2.instr_pc, bus2.illegal, bus2.pm_addr};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      mem2[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.jump_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    bus.instr_ready = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_target = 8'h77;
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (snap !== {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=%h", snap, {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00, 1'b0, 8'h00});
    end
    n_vec++;
    if (snap2 !== {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 8'hFE, 1'b0, 8'hFE}) begin
      n_err++;
      $display("FAIL reset_state_fe got=%h exp=%h", snap2, {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 8'hFE, 1'b0, 8'hFE});
    end
    bus.jump_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_len3();
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h07; mem[2] = 8'h02;
    bus.instr_ready = 1'b1;
    do_reset();
    tick();
    tick();
    n_vec++;
    if (bus.instr_valid !== 1'b0 || bus.pm_addr !== 8'h02) begin
      n_err++;
      $display("FAIL len3_early got valid=%b addr=%h exp valid=0 addr=02", bus.instr_valid, bus.pm_addr);
    end
    tick();
    n_vec++;
    if (snap !== {1'b1, 8'h05, 8'h07, 8'h02, 2'd3, 8'h00, 1'b0, 8'h03}) begin
      n_err++;
      $display("FAIL len3_valid got=%h exp=%h", snap, {1'b1, 8'h05, 8'h07, 8'h02, 2'd3, 8'h00, 1'b0, 8'h03});
    end
    tick();
    n_vec++;
    if (snap !== {1'b0, 8'h05, 8'h07, 8'h02, 2'd3, 8'h00, 1'b0, 8'h03}) begin
      n_err++;
      $display("FAIL len3_next got=%h exp=%h", snap, {1'b0, 8'h05, 8'h07, 8'h02, 2'd3, 8'h00, 1'b0, 8'h03});
    end
  endtask

  task automatic test_back_to_back();
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h12; mem[3] = 8'h00;
    bus.instr_ready = 1'b1;
    do_reset();
    tick();
    tick();
    n_vec++;
    if (snap !== {1'b1, 8'h01, 8'h03, 8'h00, 2'd2, 8'h00, 1'b0, 8'h02}) begin
      n_err++;
      $display("FAIL b2b_add got=%h exp=%h", snap, {1'b1, 8'h01, 8'h03, 8'h00, 2'd2, 8'h00, 1'b0, 8'h02});
    end
    tick();
    n_vec++;
    if (bus.instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap got=%b exp=0", bus.instr_valid);
    end
    tick();
    n_vec++;
    if (snap !== {1'b1, 8'h12, 8'h00, 8'h00, 2'd1, 8'h02, 1'b0, 8'h03}) begin
      n_err++;
      $display("FAIL b2b_clr got=%h exp=%h", snap, {1'b1, 8'h12, 8'h00, 8'h00, 2'd1, 8'h02, 1'b0, 8'h03});
    end
    tick();
    tick();
    n_vec++;
    if (snap !== {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 8'h03, 1'b0, 8'h04}) begin
      n_err++;
      $display("FAIL b2b_nop got=%h exp=%h", snap, {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 8'h03, 1'b0, 8'h04});
    end
  endtask

  task automatic test_backpressure();
    clear_mem();
    mem[0] = 8'h06; mem[1] = 8'h0C; mem[2] = 8'h03;
    bus.instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (snap !== {1'b1, 8'h06, 8'h0C, 8'h03, 2'd3, 8'h00, 1'b0, 8'h03}) begin
        n_err++;
        $display("FAIL bp_hold%0d got=%h exp=%h", c, snap, {1'b1, 8'h06, 8'h0C, 8'h03, 2'd3, 8'h00, 1'b0, 8'h03});
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    n_vec++;
    if (snap !== {1'b0, 8'h06, 8'h0C, 8'h03, 2'd3, 8'h00, 1'b0, 8'h03}) begin
      n_err++;
      $display("FAIL bp_accept got=%h exp=%h", snap, {1'b0, 8'h06, 8'h0C, 8'h03, 2'd3, 8'h00, 1'b0, 8'h03});
    end
  endtask

  task automatic test_jump();
    clear_mem();
    mem[0] = 8'h09; mem[1] = 8'hAA; mem[2] = 8'hBB;
    mem[8'h21] = 8'h00; mem[8'h40] = 8'h12;
    bus.instr_ready = 1'b1;
    do_reset();
    tick();
    bus.jump_en = 1'b1;
    bus.jump_target = 8'h21;
    tick();
    bus.jump_en = 1'b0;
    n_vec++;
    if (bus.instr_valid !== 1'b0 || bus.pm_addr !== 8'h21) begin
      n_err++;
      $display("FAIL jump_redirect got valid=%b addr=%h exp valid=0 addr=21", bus.instr_valid, bus.pm_addr);
    end
    tick();
    n_vec++;
    if (snap !== {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 8'h21, 1'b0, 8'h22}) begin
      n_err++;
      $display("FAIL jump_target_instr got=%h exp=%h", snap, {1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 8'h21, 1'b0, 8'h22});
    end
    bus.jump_en = 1'b1;
    bus.jump_target = 8'h40;
    tick();
    bus.jump_en = 1'b0;
    n_vec++;
    if (bus.instr_valid !== 1'b0 || bus.pm_addr !== 8'h40) begin
      n_err++;
      $display("FAIL jump_with_accept got valid=%b addr=%h exp valid=0 addr=40", bus.instr_valid, bus.pm_addr);
    end
    tick();
    n_vec++;
    if (snap !== {1'b1, 8'h12, 8'h00, 8'h00, 2'd1, 8'h40, 1'b0, 8'h41}) begin
      n_err++;
      $display("FAIL jump_after_accept got=%h exp=%h", snap, {1'b1, 8'h12, 8'h00, 8'h00, 2'd1, 8'h40, 1'b0, 8'h41});
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem2[8'hFE] = 8'h05; mem2[8'hFF] = 8'h07; mem2[8'h00] = 8'h02;
    do_reset();
    tick();
    tick();
    tick();
    n_vec++;
    if (snap2 !== {1'b1, 8'h05, 8'h07, 8'h02, 2'd3, 8'hFE, 1'b0, 8'h01}) begin
      n_err++;
      $display("FAIL wrap got=%h exp=%h", snap2, {1'b1, 8'h05, 8'h07, 8'h02, 2'd3, 8'hFE, 1'b0, 8'h01});
    end
  endtask

  task automatic test_illegal();
    clear_mem();
    mem[0] = 8'hFF; mem[1] = 8'h08;
    bus.instr_ready = 1'b1;
    do_reset();
    tick();
    n_vec++;
    if (snap !== {1'b1, 8'hFF, 8'h00, 8'h00, 2'd1, 8'h00, 1'b1, 8'h01}) begin
      n_err++;
      $display("FAIL illegal_ff got=%h exp=%h", snap, {1'b1, 8'hFF, 8'h00, 8'h00, 2'd1, 8'h00, 1'b1, 8'h01});
    end
    tick();
    tick();
    n_vec++;
    if (snap !== {1'b1, 8'h08, 8'h00, 8'h00, 2'd1, 8'h01, 1'b1, 8'h02}) begin
      n_err++;
      $display("FAIL illegal_08 got=%h exp=%h", snap, {1'b1, 8'h08, 8'h00, 8'h00, 2'd1, 8'h01, 1'b1, 8'h02});
    end
  endtask

  task automatic test_reset_mid_fetch();
    clear_mem();
    mem[0] = 8'h04; mem[1] = 8'h11; mem[2] = 8'h22;
    bus.instr_ready = 1'b1;
    do_reset();
    tick();
    tick();
    rst = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_target = 8'h55;
    tick();
    n_vec++;
    if (snap !== {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_mid_op2 got=%h exp=%h", snap, {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 8'h00, 1'b0, 8'h00});
    end
    bus.jump_en = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    bus.instr_ready  = 1'b0;
    bus.jump_en      = 1'b0;
    bus.jump_target  = 8'h00;
    bus2.instr_ready = 1'b1;
    bus2.jump_en     = 1'b0;
    bus2.jump_target = 8'h00;
    clear_mem();
    @(negedge clk);
    test_reset();
    test_len3();
    test_back_to_back();
    test_backpressure();
    test_jump();
    test_wrap();
    test_illegal();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
